// File: rtl/nx_msg_distributor_pkg.sv
// Shared mesh definitions: direction encoding, source identifiers and a
// direction decode helper used by the message distributor.
package nx_msg_distributor_pkg;

    localparam int NUM_DIRS = 4;

    localparam logic [1:0] DIRX_N = 2'd0;
    localparam logic [1:0] DIRX_E = 2'd1;
    localparam logic [1:0] DIRX_S = 2'd2;
    localparam logic [1:0] DIRX_W = 2'd3;

    typedef enum logic [1:0] {
        NX_DIR_N = 2'd0,
        NX_DIR_E = 2'd1,
        NX_DIR_S = 2'd2,
        NX_DIR_W = 2'd3
    } nx_direction_t;

    // Round-robin priority pointer: which source wins a same-direction contention.
    typedef enum logic {
        SRC_BYPASS = 1'b0,
        SRC_EMIT   = 1'b1
    } nx_src_t;

    function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
        logic [3:0] hot;
        case (dir)
            DIRX_N:  hot = 4'b0001;
            DIRX_E:  hot = 4'b0010;
            DIRX_S:  hot = 4'b0100;
            DIRX_W:  hot = 4'b1000;
            default: hot = 4'b0000;
        endcase
        return hot;
    endfunction

endpackage

// File: rtl/nx_dist_slot.sv
// Single-entry registered output slot for one mesh direction.
// With NX_DISTRIB_STATS_EN defined it also keeps a saturating delivery counter.
module nx_dist_slot #(
    parameter int STREAM_WIDTH = 32
`ifdef NX_DISTRIB_STATS_EN
    , parameter int STATS_WIDTH = 16
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [STREAM_WIDTH-1:0] data_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [STREAM_WIDTH-1:0] data_o,
    output logic                    avail_o
`ifdef NX_DISTRIB_STATS_EN
    , output logic [STATS_WIDTH-1:0] stat_o
`endif
);

    // Slot can take a new message when empty or when draining this cycle.
    always_comb begin
        avail_o = !valid_o || ready_i;
    end

    // Holding register: refill wins over drain, data frozen while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= {STREAM_WIDTH{1'b0}};
        end else if (push_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_o;
        end
    end

`ifdef NX_DISTRIB_STATS_EN
    // Delivery counter, sticks at all-ones once saturated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_o <= {STATS_WIDTH{1'b0}};
        end else if (valid_o && ready_i && (stat_o != {STATS_WIDTH{1'b1}})) begin
            stat_o <= stat_o + STATS_WIDTH'(1);
        end else begin
            stat_o <= stat_o;
        end
    end
`endif

endmodule

// File: rtl/nx_msg_distributor.sv
// Shares the four mesh output links between the bypass and emit streams with
// round-robin arbitration per direction. Optional stats: NX_DISTRIB_STATS_EN.
module nx_msg_distributor
    import nx_msg_distributor_pkg::*;
#(
    parameter int STREAM_WIDTH = 32
`ifdef NX_DISTRIB_STATS_EN
    , parameter int STATS_WIDTH = 16
`endif
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [STREAM_WIDTH-1:0]   bypass_data_i,
    input  logic [1:0]                bypass_dir_i,
    input  logic                      bypass_valid_i,
    output logic                      bypass_ready_o,
    input  logic [STREAM_WIDTH-1:0]   emit_data_i,
    input  logic [1:0]                emit_dir_i,
    input  logic                      emit_valid_i,
    output logic                      emit_ready_o,
    output logic [4*STREAM_WIDTH-1:0] out_data_o,
    output logic [3:0]                out_valid_o,
    input  logic [3:0]                out_ready_i
`ifdef NX_DISTRIB_STATS_EN
    , output logic [4*STATS_WIDTH-1:0] stat_sent_o
`endif
);

    logic [3:0]              avail_s;
    logic [3:0]              bypass_req_s;
    logic [3:0]              emit_req_s;
    logic [3:0]              push_s;
    logic [STREAM_WIDTH-1:0] push_data_s [NUM_DIRS];
    logic                    same_dir_s;
    logic                    bypass_gnt_s;
    logic                    emit_gnt_s;
    nx_src_t                 prio_r;
    nx_src_t                 prio_next_s;

    // Request decode and grant; the pointer only matters when both target one slot.
    always_comb begin
        bypass_req_s = 4'b0000;
        emit_req_s   = 4'b0000;
        if (bypass_valid_i) begin
            bypass_req_s = dir_onehot(bypass_dir_i);
        end else begin
            bypass_req_s = 4'b0000;
        end
        if (emit_valid_i) begin
            emit_req_s = dir_onehot(emit_dir_i);
        end else begin
            emit_req_s = 4'b0000;
        end
        same_dir_s   = |(bypass_req_s & emit_req_s);
        bypass_gnt_s = (|(bypass_req_s & avail_s)) && (!same_dir_s || (prio_r == SRC_BYPASS));
        emit_gnt_s   = (|(emit_req_s & avail_s)) && (!same_dir_s || (prio_r == SRC_EMIT));
    end

    assign bypass_ready_o = bypass_gnt_s;
    assign emit_ready_o   = emit_gnt_s;

    // Route granted messages to their slots; grants never collide on one slot.
    always_comb begin
        push_s = 4'b0000;
        for (int d = 0; d < NUM_DIRS; d++) begin
            push_data_s[d] = emit_data_i;
            if (bypass_gnt_s && bypass_req_s[d]) begin
                push_s[d]      = 1'b1;
                push_data_s[d] = bypass_data_i;
            end else if (emit_gnt_s && emit_req_s[d]) begin
                push_s[d]      = 1'b1;
                push_data_s[d] = emit_data_i;
            end else begin
                push_s[d]      = 1'b0;
            end
        end
    end

    // Pointer next state: hand priority over once the favoured source is served.
    always_comb begin
        prio_next_s = prio_r;
        case (prio_r)
            SRC_BYPASS: begin
                if (bypass_gnt_s) begin
                    prio_next_s = SRC_EMIT;
                end else begin
                    prio_next_s = SRC_BYPASS;
                end
            end
            SRC_EMIT: begin
                if (emit_gnt_s) begin
                    prio_next_s = SRC_BYPASS;
                end else begin
                    prio_next_s = SRC_EMIT;
                end
            end
            default: prio_next_s = SRC_BYPASS;
        endcase
    end

    // Priority pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_r <= SRC_BYPASS;
        end else begin
            prio_r <= prio_next_s;
        end
    end

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_slot
        nx_dist_slot #(
            .STREAM_WIDTH (STREAM_WIDTH)
`ifdef NX_DISTRIB_STATS_EN
            , .STATS_WIDTH (STATS_WIDTH)
`endif
        ) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push_s[d]),
            .data_i  (push_data_s[d]),
            .ready_i (out_ready_i[d]),
            .valid_o (out_valid_o[d]),
            .data_o  (out_data_o[d*STREAM_WIDTH +: STREAM_WIDTH]),
            .avail_o (avail_s[d])
`ifdef NX_DISTRIB_STATS_EN
            , .stat_o (stat_sent_o[d*STATS_WIDTH +: STATS_WIDTH])
`endif
        );
    end

endmodule

// File: tb/tb_nx_msg_distributor.sv
// Scoreboard bench for nx_msg_distributor: stimulus queues expected deliveries
// per direction, a negedge monitor pops and compares on every handshake.
module tb_nx_msg_distributor;

    logic         clk;
    logic         rst;
    logic [31:0]  bypass_data;
    logic [1:0]   bypass_dir;
    logic         bypass_valid;
    logic         bypass_ready;
    logic [31:0]  emit_data;
    logic [1:0]   emit_dir;
    logic         emit_valid;
    logic         emit_ready;
    logic [127:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
`ifdef NX_DISTRIB_STATS_EN
    logic [7:0]   stat_sent;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] q_n[$];
    logic [31:0] q_e[$];
    logic [31:0] q_s[$];
    logic [31:0] q_w[$];

    nx_msg_distributor #(
        .STREAM_WIDTH (32)
`ifdef NX_DISTRIB_STATS_EN
        , .STATS_WIDTH (2)
`endif
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bypass_data_i  (bypass_data),
        .bypass_dir_i   (bypass_dir),
        .bypass_valid_i (bypass_valid),
        .bypass_ready_o (bypass_ready),
        .emit_data_i    (emit_data),
        .emit_dir_i     (emit_dir),
        .emit_valid_i   (emit_valid),
        .emit_ready_o   (emit_ready),
        .out_data_o     (out_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready)
`ifdef NX_DISTRIB_STATS_EN
        , .stat_sent_o  (stat_sent)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic [31:0] v);
        case (d)
            0: q_n.push_back(v);
            1: q_e.push_back(v);
            2: q_s.push_back(v);
            default: q_w.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int d, output logic [31:0] v, output bit ok);
        ok = 1'b0;
        v  = 32'h0;
        case (d)
            0: if (q_n.size() > 0) begin v = q_n.pop_front(); ok = 1'b1; end
            1: if (q_e.size() > 0) begin v = q_e.pop_front(); ok = 1'b1; end
            2: if (q_s.size() > 0) begin v = q_s.pop_front(); ok = 1'b1; end
            default: if (q_w.size() > 0) begin v = q_w.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Monitor: every handshake must match the next queued message of its direction.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        bit          ok;
        if (!rst) begin
            for (int d = 0; d < 4; d++) begin
                if (out_valid[d] && out_ready[d]) begin
                    pop_exp(d, e, ok);
                    if (!ok) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_deliver_d%0d: got %h expected none", d, out_data[d*32 +: 32]);
                    end else begin
                        chk($sformatf("deliver_d%0d", d), {96'h0, out_data[d*32 +: 32]}, {96'h0, e});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bypass_data  = 32'h0;
        bypass_dir   = 2'd0;
        bypass_valid = 1'b0;
        emit_data    = 32'h0;
        emit_dir     = 2'd0;
        emit_valid   = 1'b0;
        out_ready    = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", {124'h0, out_valid}, 128'h0);
        chk("reset_data", out_data, 128'h0);

        // 1: single bypass to E, visible for exactly one cycle
        bypass_valid = 1'b1; bypass_dir = 2'd1; bypass_data = 32'hDEADBEEF;
        #1;
        chk("t1_bypass_ready", {127'h0, bypass_ready}, 128'h1);
        push_exp(1, 32'hDEADBEEF);
        tick();
        bypass_valid = 1'b0;
        chk("t1_valid", {124'h0, out_valid}, {124'h0, 4'b0010});
        chk("t1_slice1", {96'h0, out_data[63:32]}, {96'h0, 32'hDEADBEEF});
        tick();
        chk("t1_valid_cleared", {124'h0, out_valid}, 128'h0);

        // 2: contention on N alternates bypass, emit, bypass, emit
        do_reset();
        bypass_valid = 1'b1; bypass_dir = 2'd0; bypass_data = 32'h11111111;
        emit_valid   = 1'b1; emit_dir   = 2'd0; emit_data   = 32'h22222222;
        #1;
        chk("t2_c1_bypass_ready", {127'h0, bypass_ready}, 128'h1);
        chk("t2_c1_emit_ready", {127'h0, emit_ready}, 128'h0);
        push_exp(0, 32'h11111111);
        push_exp(0, 32'h22222222);
        tick();
        bypass_data = 32'h33333333;
        push_exp(0, 32'h33333333);
        #1;
        chk("t2_c2_emit_ready", {127'h0, emit_ready}, 128'h1);
        chk("t2_c2_bypass_ready", {127'h0, bypass_ready}, 128'h0);
        chk("t2_c2_slice0", {96'h0, out_data[31:0]}, {96'h0, 32'h11111111});
        tick();
        emit_data = 32'h44444444;
        push_exp(0, 32'h44444444);
        #1;
        chk("t2_c3_bypass_ready", {127'h0, bypass_ready}, 128'h1);
        chk("t2_c3_emit_ready", {127'h0, emit_ready}, 128'h0);
        chk("t2_c3_slice0", {96'h0, out_data[31:0]}, {96'h0, 32'h22222222});
        tick();
        bypass_valid = 1'b0;
        #1;
        chk("t2_c4_emit_ready", {127'h0, emit_ready}, 128'h1);
        chk("t2_c4_slice0", {96'h0, out_data[31:0]}, {96'h0, 32'h33333333});
        tick();
        emit_valid = 1'b0;
        chk("t2_c5_slice0", {96'h0, out_data[31:0]}, {96'h0, 32'h44444444});
        tick();
        chk("t2_drained", {124'h0, out_valid}, 128'h0);

        // 3: different directions granted together
        bypass_valid = 1'b1; bypass_dir = 2'd2; bypass_data = 32'hA5A5A5A5;
        emit_valid   = 1'b1; emit_dir   = 2'd3; emit_data   = 32'h5A5A5A5A;
        #1;
        chk("t3_bypass_ready", {127'h0, bypass_ready}, 128'h1);
        chk("t3_emit_ready", {127'h0, emit_ready}, 128'h1);
        push_exp(2, 32'hA5A5A5A5);
        push_exp(3, 32'h5A5A5A5A);
        tick();
        bypass_valid = 1'b0; emit_valid = 1'b0;
        chk("t3_valid", {124'h0, out_valid}, {124'h0, 4'b1100});
        chk("t3_slice2", {96'h0, out_data[95:64]}, {96'h0, 32'hA5A5A5A5});
        chk("t3_slice3", {96'h0, out_data[127:96]}, {96'h0, 32'h5A5A5A5A});
        tick();

        // 4: stalled S slot holds data and back-pressures bypass, then refills with no bubble
        out_ready = 4'b1011;
        bypass_valid = 1'b1; bypass_dir = 2'd2; bypass_data = 32'h0BADF00D;
        #1;
        chk("t4_first_ready", {127'h0, bypass_ready}, 128'h1);
        push_exp(2, 32'h0BADF00D);
        tick();
        bypass_data = 32'hC0FFEE00;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t4_stall%0d_ready", i), {127'h0, bypass_ready}, 128'h0);
            chk($sformatf("t4_stall%0d_slice2", i), {96'h0, out_data[95:64]}, {96'h0, 32'h0BADF00D});
            tick();
        end
        out_ready = 4'hF;
        #1;
        chk("t4_release_ready", {127'h0, bypass_ready}, 128'h1);
        push_exp(2, 32'hC0FFEE00);
        tick();
        bypass_valid = 1'b0;
        chk("t4_refill_valid", {127'h0, out_valid[2]}, 128'h1);
        chk("t4_refill_slice2", {96'h0, out_data[95:64]}, {96'h0, 32'hC0FFEE00});
        tick();
        chk("t4_drained", {127'h0, out_valid[2]}, 128'h0);

        // 5: reset discards buffered N and E messages
        out_ready = 4'h0;
        bypass_valid = 1'b1; bypass_dir = 2'd0; bypass_data = 32'h12345678;
        emit_valid   = 1'b1; emit_dir   = 2'd1; emit_data   = 32'h87654321;
        tick();
        bypass_valid = 1'b0; emit_valid = 1'b0;
        chk("t5_full", {124'h0, out_valid}, {124'h0, 4'b0011});
        do_reset();
        chk("t5_reset_valid", {124'h0, out_valid}, 128'h0);
        chk("t5_reset_data", out_data, 128'h0);
        out_ready = 4'hF;
        bypass_valid = 1'b1; bypass_dir = 2'd0; bypass_data = 32'h0F0F0F0F;
        #1;
        chk("t5_fresh_ready", {127'h0, bypass_ready}, 128'h1);
        push_exp(0, 32'h0F0F0F0F);
        tick();
        bypass_valid = 1'b0;
        chk("t5_fresh_valid", {124'h0, out_valid}, {124'h0, 4'b0001});
        chk("t5_fresh_slice0", {96'h0, out_data[31:0]}, {96'h0, 32'h0F0F0F0F});
        tick();

`ifdef NX_DISTRIB_STATS_EN
        // 6: 2-bit W counter saturates at 3
        begin
            logic [1:0] stat_exp [5];
            stat_exp[0] = 2'd1; stat_exp[1] = 2'd2; stat_exp[2] = 2'd3;
            stat_exp[3] = 2'd3; stat_exp[4] = 2'd3;
            do_reset();
            chk("t6_stat_reset", {120'h0, stat_sent}, 128'h0);
            for (int k = 0; k < 5; k++) begin
                bypass_valid = 1'b1; bypass_dir = 2'd3; bypass_data = 32'h70000000 + k;
                push_exp(3, 32'h70000000 + k);
                tick();
                bypass_valid = 1'b0;
                tick();
                chk($sformatf("t6_stat_w%0d", k), {126'h0, stat_sent[7:6]}, {126'h0, stat_exp[k]});
                chk($sformatf("t6_stat_others%0d", k), {122'h0, stat_sent[5:0]}, 128'h0);
            end
        end
`endif

        tick();
        tick();
        chk("end_q_n_empty", 128'(q_n.size()), 128'h0);
        chk("end_q_e_empty", 128'(q_e.size()), 128'h0);
        chk("end_q_s_empty", 128'(q_s.size()), 128'h0);
        chk("end_q_w_empty", 128'(q_w.size()), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
